// File: rtl/mem_result_reader_pkg.sv
// Shared constants and types for the result reader.
// Holds the engine-wide values (memory address width, thread-state encoding)
// next to the result-frame header layout and the per-frame length limit.
package mem_result_reader_pkg;

    localparam int unsigned N_THREADS_DEF    = 16;
    localparam int unsigned MEM_TOTAL_MSB    = 9;
    localparam int unsigned THREAD_STATE_MSB = 1;

    localparam logic [THREAD_STATE_MSB:0] THREAD_STATE_NONE = 2'b00;

    // Result frame header: marker | length | thread number.
    localparam logic [7:0]  HDR_MARKER     = 8'hA5;
    localparam int unsigned HDR_MARKER_LSB = 24;
    localparam int unsigned HDR_LEN_LSB    = 16;
    localparam int unsigned HDR_THREAD_LSB = 0;

    localparam logic [4:0] MAX_LEN = 5'd16;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StRead,
        StDrain,
        StTswr
    } state_e;

    // Index of the most significant set bit; 0 for inputs of 0 or 1.
    function automatic int unsigned msb_of(input int unsigned v);
        return (v <= 1) ? 0 : $clog2(v + 1) - 1;
    endfunction

    function automatic logic [31:0] make_header(input logic [4:0] len,
                                                input logic [15:0] thread);
        logic [31:0] w;
        w = '0;
        w[HDR_MARKER_LSB +: 8] = HDR_MARKER;
        w[HDR_LEN_LSB +: 8]    = {3'b000, len};
        w[HDR_THREAD_LSB +: 16] = thread;
        return w;
    endfunction

endpackage

// File: rtl/fwft_fifo.sv
// First-word-fall-through FIFO.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset (flushes contents)
//   push_i, wdata_i      write; ignored when full unless a pop happens in the same cycle
//   pop_i                take the head word; ignored when empty
//   rdata_o, empty_o     head word (zero when empty), empty flag
//   count_o              current occupancy, 0..Depth
// Depth must be a power of two so the pointers wrap naturally.
module fwft_fifo #(
    parameter int unsigned Width = 33,
    parameter int unsigned Depth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [Width-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [Width-1:0]       rdata_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] count_o
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam int unsigned CntW  = AddrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             full, do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CntW'(Depth));
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO can still accept a word when the head leaves in the same cycle.
    assign do_push = push_i && (!full || do_pop);

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/mem_result_reader.sv
// Result reader: fetches cmd_len words from engine memory and streams them to the
// host as one frame (header word, then data words), then releases the thread.
// Ports:
//   CLK, RST_N                         clock, asynchronous active-low reset
//   cmd_valid/cmd_ready                command handshake (ready only while idle)
//   cmd_thread_num, cmd_addr, cmd_len  thread, base word address, word count 0..16
//   mem_rd_cpu_request/mem_rd_addr_cpu level read request and its address
//   mem_dout/mem_rd_cpu_valid          read data and completion strobe
//   out_valid/out_ready/out_data/out_last  framed output stream
//   ts_wr_num/ts_wr_en/ts_wr           thread-state write (back to NONE)
//   busy                               frame in progress
//   err                                sticky protocol error
module mem_result_reader
    import mem_result_reader_pkg::*;
#(
    parameter int unsigned N_THREADS     = N_THREADS_DEF,
    parameter int unsigned N_THREADS_MSB = msb_of(N_THREADS - 1),
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [N_THREADS_MSB:0]      cmd_thread_num,
    input  logic [MEM_TOTAL_MSB:0]      cmd_addr,
    input  logic [4:0]                  cmd_len,
    output logic                        mem_rd_cpu_request,
    output logic [MEM_TOTAL_MSB:0]      mem_rd_addr_cpu,
    input  logic [31:0]                 mem_dout,
    input  logic                        mem_rd_cpu_valid,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [31:0]                 out_data,
    output logic                        out_last,
    output logic [N_THREADS_MSB:0]      ts_wr_num,
    output logic                        ts_wr_en,
    output logic [THREAD_STATE_MSB:0]   ts_wr,
    output logic                        busy,
    output logic                        err
);

    localparam int unsigned AddrW = MEM_TOTAL_MSB + 1;
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;

    state_e                 state_q, state_d;
    logic [N_THREADS_MSB:0] thread_q, thread_d;
    logic [AddrW-1:0]       addr_q, addr_d;
    logic [4:0]             len_q, len_d;
    logic [4:0]             remain_q, remain_d;
    logic                   err_q, err_d;
    logic                   init_q;

    logic                   cmd_fire, req, rd_done;
    logic [4:0]             len_clamped;
    logic                   fifo_push, fifo_empty;
    logic [32:0]            fifo_wdata, fifo_rdata;
    logic [CntW-1:0]        fifo_count;

    // init_q keeps cmd_ready low until the first edge after reset release.
    assign cmd_fire    = cmd_valid && cmd_ready;
    assign len_clamped = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
    // One outstanding read; the FIFO must keep a free slot for it.
    assign req         = (state_q == StRead) && (fifo_count < CntW'(FIFO_DEPTH));
    assign rd_done     = req && mem_rd_cpu_valid;

    always_comb begin
        state_d    = state_q;
        thread_d   = thread_q;
        addr_d     = addr_q;
        len_d      = len_q;
        remain_d   = remain_q;
        fifo_push  = 1'b0;
        fifo_wdata = '0;
        err_d      = err_q;

        if (mem_rd_cpu_valid && !req) err_d = 1'b1;
        if (cmd_fire && (cmd_len > MAX_LEN)) err_d = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    thread_d = cmd_thread_num;
                    addr_d   = cmd_addr;
                    len_d    = len_clamped;
                    remain_d = len_clamped;
                    state_d  = StHdr;
                end
            end
            StHdr: begin
                // The FIFO is always empty here, so the header push cannot be refused.
                fifo_push  = 1'b1;
                fifo_wdata = {(len_q == 5'd0), make_header(len_q, 16'(thread_q))};
                state_d    = (len_q == 5'd0) ? StDrain : StRead;
            end
            StRead: begin
                if (rd_done) begin
                    fifo_push  = 1'b1;
                    fifo_wdata = {(remain_q == 5'd1), mem_dout};
                    addr_d     = addr_q + AddrW'(1);
                    remain_d   = remain_q - 5'd1;
                    if (remain_q == 5'd1) state_d = StDrain;
                end
            end
            StDrain: begin
                if (fifo_empty) state_d = StTswr;
            end
            StTswr: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= StIdle;
            thread_q <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            remain_q <= '0;
            err_q    <= 1'b0;
            init_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            thread_q <= thread_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            remain_q <= remain_d;
            err_q    <= err_d;
            init_q   <= 1'b1;
        end
    end

    fwft_fifo #(
        .Width (33),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (out_ready),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign out_valid          = !fifo_empty;
    assign out_last           = fifo_rdata[32];
    assign out_data           = fifo_rdata[31:0];
    assign cmd_ready          = init_q && (state_q == StIdle);
    assign mem_rd_cpu_request = req;
    assign mem_rd_addr_cpu    = req ? addr_q : '0;
    assign ts_wr_en           = (state_q == StTswr);
    assign ts_wr_num          = ts_wr_en ? thread_q : '0;
    assign ts_wr              = ts_wr_en ? THREAD_STATE_NONE : '0;
    assign busy               = (state_q != StIdle);
    assign err                = err_q;

endmodule

// File: tb/tb_mem_result_reader.sv
module tb_mem_result_reader;
    import mem_result_reader_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_thread_num = '0;
    logic [9:0]  cmd_addr = '0;
    logic [4:0]  cmd_len = '0;
    logic        mem_req;
    logic [9:0]  mem_addr;
    logic [31:0] mem_dout = '0;
    logic        mem_valid = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic [3:0]  ts_wr_num;
    logic        ts_wr_en;
    logic [1:0]  ts_wr;
    logic        busy;
    logic        err;

    always #5 CLK = ~CLK;

    mem_result_reader #(
        .N_THREADS     (16),
        .N_THREADS_MSB (3),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .CLK                (CLK),
        .RST_N              (RST_N),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_thread_num     (cmd_thread_num),
        .cmd_addr           (cmd_addr),
        .cmd_len            (cmd_len),
        .mem_rd_cpu_request (mem_req),
        .mem_rd_addr_cpu    (mem_addr),
        .mem_dout           (mem_dout),
        .mem_rd_cpu_valid   (mem_valid),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_data           (out_data),
        .out_last           (out_last),
        .ts_wr_num          (ts_wr_num),
        .ts_wr_en           (ts_wr_en),
        .ts_wr              (ts_wr),
        .busy               (busy),
        .err                (err)
    );

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return {6'h2B, a, 6'h15, a};
    endfunction

    // Frame model: expected output words, read progress, thread-state timing.
    logic [31:0] exp_q[$];
    int unsigned fr_len = 0, fr_done = 0, fr_popped = 0, since_last = 100;
    logic [9:0]  fr_addr = '0;
    logic [3:0]  fr_thread = '0;
    bit          err_exp = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data = '0;

    // Memory model: answers a held request after mem_lat cycles.
    int          mem_lat = 2;
    int          mem_cnt = 0;
    bit          inject = 0;

    always @(posedge CLK) begin
        #1;
        if (!RST_N) begin
            mem_valid = 1'b0;
            mem_cnt = 0;
        end else begin
            if (mem_valid) begin
                mem_valid = 1'b0;
                mem_cnt = 0;
            end
            if (inject) begin
                mem_valid = 1'b1;
                inject = 0;
            end else if (mem_req) begin
                mem_cnt++;
                if (mem_cnt >= mem_lat) begin
                    mem_valid = 1'b1;
                    mem_dout = mem_word(mem_addr);
                end
            end
        end
    end

    // out_ready driver: 0 low, 1 high, 2 toggling every cycle.
    int rdy_mode = 1;
    always @(posedge CLK) begin
        #3;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ~out_ready;
        endcase
    end

    always @(negedge CLK) begin
        if (!RST_N) begin
            chk("rst_ctrl", 32'({cmd_ready, mem_req, out_valid, out_last, ts_wr_en, busy, err}), 0);
            chk("rst_data", out_data, 0);
            chk("rst_misc", 32'({mem_addr, ts_wr_num, ts_wr}), 0);
            exp_q.delete();
            fr_done = 0;
            fr_popped = 0;
            fr_len = 0;
            since_last = 100;
            err_exp = 0;
            prev_stall = 0;
        end else begin
            if (since_last < 100) since_last++;
            chk("ts_wr_en", 32'(ts_wr_en), 32'(since_last == 2));
            if (since_last == 2) begin
                chk("ts_wr_num", 32'(ts_wr_num), 32'(fr_thread));
                chk("ts_wr", 32'(ts_wr), 32'(THREAD_STATE_NONE));
                chk("cmd_ready_in_tswr", 32'(cmd_ready), 0);
            end
            if (since_last == 3) chk("cmd_ready_back", 32'(cmd_ready), 1);
            if (exp_q.size() != 0) chk("busy", 32'(busy), 1);
            if (err_exp) chk("err_sticky", 32'(err), 1);
            if (prev_stall) chk("out_hold", out_data, prev_data);
            if (mem_req) begin
                chk("rd_addr", 32'(mem_addr), 32'(10'(fr_addr + 10'(fr_done))));
                chk("rd_not_past_len", 32'(fr_done < fr_len), 1);
                chk("rd_fifo_space", 32'((1 + fr_done - fr_popped) < DEPTH), 1);
                if (mem_valid) fr_done++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("out_unexpected_word", out_data, 32'hDEAD_BEEF);
                end else begin
                    logic [31:0] w;
                    w = exp_q.pop_front();
                    chk("out_data", out_data, w);
                    chk("out_last", 32'(out_last), 32'(exp_q.size() == 0));
                    fr_popped++;
                    if (exp_q.size() == 0) since_last = 0;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    task automatic send_cmd(input logic [3:0] th, input logic [9:0] a, input logic [4:0] len);
        int unsigned n;
        int unsigned l;
        n = 0;
        @(posedge CLK); #1;
        while (!cmd_ready && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!cmd_ready) begin
            chk("cmd_ready_timeout", 32'(cmd_ready), 1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_thread_num = th;
        cmd_addr = a;
        cmd_len = len;
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        l = (len > 16) ? 16 : int'(len);
        fr_len = l;
        fr_done = 0;
        fr_popped = 0;
        fr_addr = a;
        fr_thread = th;
        since_last = 100;
        exp_q.push_back({8'hA5, 8'(l), 12'd0, th});
        for (int i = 0; i < int'(l); i++) exp_q.push_back(mem_word(10'(a + 10'(i))));
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge CLK); #2;
            if (exp_q.size() == 0 && since_last >= 3) return;
        end
        chk(name, 32'(exp_q.size()), 0);
    endtask

    initial begin
        #1 RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        #2 RST_N = 1'b1;
        #1 chk("ready_before_first_edge", 32'(cmd_ready), 0);
        @(posedge CLK); #1;
        chk("ready_after_first_edge", 32'(cmd_ready), 1);

        // Basic read.
        rdy_mode = 1;
        mem_lat = 2;
        send_cmd(4'd5, 10'h100, 5'd3);
        chk("basic_ready_low", 32'(cmd_ready), 0);
        @(posedge CLK); #1;
        chk("basic_hdr_valid", 32'(out_valid), 1);
        chk("basic_hdr", out_data, 32'hA503_0005);
        chk("basic_hdr_last", 32'(out_last), 0);
        chk("basic_req", 32'(mem_req), 1);
        chk("basic_addr", 32'(mem_addr), 32'h100);
        wait_idle("basic_timeout", 100);

        // Zero length.
        send_cmd(4'd2, 10'h055, 5'd0);
        @(posedge CLK); #1;
        chk("zero_hdr", out_data, 32'hA500_0002);
        chk("zero_last", 32'(out_last), 1);
        chk("zero_no_req", 32'(mem_req), 0);
        wait_idle("zero_timeout", 50);

        // Address wrap.
        send_cmd(4'd9, 10'h3FF, 5'd2);
        @(posedge CLK); #1;
        chk("wrap_first_addr", 32'(mem_addr), 32'h3FF);
        wait_idle("wrap_timeout", 100);

        // Backpressure.
        rdy_mode = 0;
        send_cmd(4'd7, 10'h200, 5'd16);
        repeat (40) @(posedge CLK);
        #1;
        chk("bp_req_stopped", 32'(mem_req), 0);
        chk("bp_head_hdr", out_data, 32'hA510_0007);
        chk("bp_reads_done", 32'(fr_done), 3);
        rdy_mode = 1;
        wait_idle("bp_timeout", 300);

        // Spurious completion in idle, then a clamped over-length frame.
        chk("err_clear", 32'(err), 0);
        @(negedge CLK);
        inject = 1;
        @(posedge CLK);
        @(posedge CLK); #1;
        chk("err_set", 32'(err), 1);
        err_exp = 1;
        rdy_mode = 2;
        mem_lat = 3;
        send_cmd(4'd3, 10'h010, 5'd20);
        @(posedge CLK); #1;
        chk("clamp_hdr", out_data, 32'hA510_0003);
        wait_idle("err_frame_timeout", 400);
        chk("err_still_set", 32'(err), 1);

        // Mid-frame reset after the second read.
        rdy_mode = 1;
        mem_lat = 1;
        send_cmd(4'd6, 10'h080, 5'd8);
        for (int n = 0; n < 100 && fr_done < 2; n++) begin
            @(negedge CLK); #2;
        end
        chk("abort_reached_2_reads", 32'(fr_done), 2);
        @(posedge CLK); #2;
        RST_N = 1'b0;
        #1;
        chk("abort_req", 32'(mem_req), 0);
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ts", 32'(ts_wr_en), 0);
        repeat (3) @(negedge CLK);
        #2 RST_N = 1'b1;
        @(posedge CLK); #1;
        chk("abort_ready_again", 32'(cmd_ready), 1);
        mem_lat = 2;
        send_cmd(4'd1, 10'h2A0, 5'd4);
        @(posedge CLK); #1;
        chk("after_abort_hdr", out_data, 32'hA504_0001);
        wait_idle("after_abort_timeout", 100);

        repeat (3) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d vectors, want completion",
                 vectors);
        $fatal(1, "watchdog expired");
    end

endmodule
